// File: rtl/dpram_pkg.sv
// Shared constants and types for the FIFO controller and its dual-port RAM.
// ADDR_W : RAM address width (5 bits -> 32 words)
// DATA_W : word width (32 bits)
// DEPTH  : number of words in the RAM
package dpram_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    // One bit wider than the address so that a completely full FIFO (32) is representable.
    typedef logic [ADDR_W:0]   cnt_t;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Push/pop request interface of the FIFO controller.
// Requests : PUSH, WDATA, POP
// Responses: RDATA, RVALID (read return), FULL, EMPTY, AFULL, COUNT (status),
//            OVF, UDF (one-cycle rejection pulses)
// slave  modport: the controller side
// master modport: the requester side
interface dpram_fifo_ctrl_if;
    import dpram_pkg::*;

    logic  PUSH;
    word_t WDATA;
    logic  POP;
    word_t RDATA;
    logic  RVALID;
    logic  FULL;
    logic  EMPTY;
    logic  AFULL;
    cnt_t  COUNT;
    logic  OVF;
    logic  UDF;

    modport slave (
        input  PUSH, WDATA, POP,
        output RDATA, RVALID, FULL, EMPTY, AFULL, COUNT, OVF, UDF
    );

    modport master (
        output PUSH, WDATA, POP,
        input  RDATA, RVALID, FULL, EMPTY, AFULL, COUNT, OVF, UDF
    );

endinterface

// File: rtl/dpram32x32_cb.sv
// Behavioural 32x32 dual-port RAM with active-low controls.
// CEB1/CEB2 : port clocks, rising-edge
// A1, I1    : port-1 address and write data
// WEB1, CSB1, OEB1 : port-1 write enable, chip select, output enable
// O1        : port-1 read data (0 while OEB1=1)
// A2        : port-2 address
// WEB2, CSB2, OEB2 : port-2 controls (port 2 reads only when WEB2=1)
// O2        : port-2 read data (0 while OEB2=1)
module dpram32x32_cb
    import dpram_pkg::*;
(
    input  logic  CEB1,
    input  addr_t A1,
    input  word_t I1,
    input  logic  WEB1,
    input  logic  CSB1,
    input  logic  OEB1,
    output word_t O1,
    input  logic  CEB2,
    input  addr_t A2,
    input  logic  WEB2,
    input  logic  CSB2,
    input  logic  OEB2,
    output word_t O2
);

    word_t mem [DEPTH];
    word_t dout1_q;
    word_t dout2_q;

    always_ff @(posedge CEB1) begin
        if (!CSB1) begin
            if (!WEB1) begin
                mem[A1] <= I1;
            end else begin
                dout1_q <= mem[A1];
            end
        end
    end

    always_ff @(posedge CEB2) begin
        if (!CSB2 && WEB2) begin
            dout2_q <= mem[A2];
        end
    end

    assign O1 = OEB1 ? '0 : dout1_q;
    assign O2 = OEB2 ? '0 : dout2_q;

endmodule

// File: rtl/dpram_fifo_ptr.sv
// Pointer, occupancy and flag logic of the FIFO controller.
// clk, rst             : clock, asynchronous active-high reset
// push_i, pop_i        : raw requests
// push_ok_o, pop_ok_o  : accepted requests (combinational from registered state)
// wr_ptr_o, rd_ptr_o   : RAM write / read pointers
// count_o              : occupancy 0..DEPTH
// full_o, empty_o, afull_o : flags decoded from the registered count
// ovf_o, udf_o         : registered one-cycle pulses for rejected push / pop
module dpram_fifo_ptr
    import dpram_pkg::*;
#(
    parameter int AFULL_TH = 28
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    output logic  push_ok_o,
    output logic  pop_ok_o,
    output addr_t wr_ptr_o,
    output addr_t rd_ptr_o,
    output cnt_t  count_o,
    output logic  full_o,
    output logic  empty_o,
    output logic  afull_o,
    output logic  ovf_o,
    output logic  udf_o
);

    localparam cnt_t FULL_CNT  = cnt_t'(DEPTH);
    localparam cnt_t AFULL_CNT = cnt_t'(AFULL_TH);

    addr_t wr_ptr_q, wr_ptr_d;
    addr_t rd_ptr_q, rd_ptr_d;
    cnt_t  count_q, count_d;
    logic  ovf_q, ovf_d;
    logic  udf_q, udf_d;

    logic  full;
    logic  empty;
    logic  push_ok;
    logic  pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Requests are masked while reset is held so the RAM sees idle controls.
    assign push_ok = push_i & ~full & ~rst;
    assign pop_ok  = pop_i & ~empty & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push_i & full;
        udf_d    = pop_i & empty;

        // Pointers wrap 31 -> 0 through natural overflow of addr_t.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + addr_t'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + addr_t'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign push_ok_o = push_ok;
    assign pop_ok_o  = pop_ok;
    assign wr_ptr_o  = wr_ptr_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign count_o   = count_q;
    assign full_o    = full;
    assign empty_o   = empty;
    assign afull_o   = (count_q >= AFULL_CNT);
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a 32x32 dual-port RAM (port 1 write-only,
// port 2 read-only, active-low controls).
// CLK, RST          : clock (also the RAM port clocks), asynchronous active-high reset
// fifo              : push/pop request interface (slave side)
// A1, I1            : RAM port-1 address (write pointer) and data
// WEB1, CSB1, OEB1  : RAM port-1 controls
// A2                : RAM port-2 address (read pointer)
// WEB2, CSB2, OEB2  : RAM port-2 controls
// O2                : RAM port-2 read data
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int AFULL_TH = 28
) (
    input  logic                     CLK,
    input  logic                     RST,
    dpram_fifo_ctrl_if.slave         fifo,
    output addr_t                    A1,
    output word_t                    I1,
    output logic                     WEB1,
    output logic                     CSB1,
    output logic                     OEB1,
    output addr_t                    A2,
    output logic                     WEB2,
    output logic                     CSB2,
    output logic                     OEB2,
    input  word_t                    O2
);

    logic  push_ok;
    logic  pop_ok;
    addr_t wr_ptr;
    addr_t rd_ptr;
    cnt_t  count;
    logic  full;
    logic  empty;
    logic  afull;
    logic  ovf;
    logic  udf;
    logic  rvalid_q, rvalid_d;

    dpram_fifo_ptr #(
        .AFULL_TH (AFULL_TH)
    ) u_ptr (
        .clk       (CLK),
        .rst       (RST),
        .push_i    (fifo.PUSH),
        .pop_i     (fifo.POP),
        .push_ok_o (push_ok),
        .pop_ok_o  (pop_ok),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty),
        .afull_o   (afull),
        .ovf_o     (ovf),
        .udf_o     (udf)
    );

    // RAM controls are combinational from the current pointers and requests;
    // the RAM samples them on the same edge that advances the pointers.
    assign A1   = wr_ptr;
    assign I1   = fifo.WDATA;
    assign CSB1 = ~push_ok;
    assign WEB1 = ~push_ok;
    assign OEB1 = 1'b1;

    assign A2   = rd_ptr;
    assign CSB2 = ~pop_ok;
    assign WEB2 = 1'b1;
    // RAM output is only enabled in the cycle its read data is returned.
    assign OEB2 = ~rvalid_q;

    // Read data appears one cycle after the accepted pop.
    assign rvalid_d = pop_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign fifo.RVALID = rvalid_q;
    assign fifo.RDATA  = rvalid_q ? O2 : '0;
    assign fifo.COUNT  = count;
    assign fifo.FULL   = full;
    assign fifo.EMPTY  = empty;
    assign fifo.AFULL  = afull;
    assign fifo.OVF    = ovf;
    assign fifo.UDF    = udf;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl attached to dpram32x32_cb.
module tb_dpram_fifo_ctrl;
    import dpram_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    dpram_fifo_ctrl_if fifo ();

    addr_t A1, A2;
    word_t I1, O1, O2;
    logic  WEB1, CSB1, OEB1, WEB2, CSB2, OEB2;

    dpram_fifo_ctrl #(
        .AFULL_TH (28)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .fifo (fifo),
        .A1   (A1),
        .I1   (I1),
        .WEB1 (WEB1),
        .CSB1 (CSB1),
        .OEB1 (OEB1),
        .A2   (A2),
        .WEB2 (WEB2),
        .CSB2 (CSB2),
        .OEB2 (OEB2),
        .O2   (O2)
    );

    dpram32x32_cb ram (
        .CEB1 (CLK),
        .A1   (A1),
        .I1   (I1),
        .WEB1 (WEB1),
        .CSB1 (CSB1),
        .OEB1 (OEB1),
        .O1   (O1),
        .CEB2 (CLK),
        .A2   (A2),
        .WEB2 (WEB2),
        .CSB2 (CSB2),
        .OEB2 (OEB2),
        .O2   (O2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO is a queue of words; pointers are just
    // the number of accepted pushes/pops modulo the depth.
    word_t q[$];
    int    n_push;
    int    n_pop;
    int    cyc;
    logic  exp_rvalid;
    word_t exp_rdata;
    logic  exp_ovf;
    logic  exp_udf;

    typedef struct {
        logic  push;
        word_t wdata;
        logic  pop;
        int    count;
        logic  rvalid;
        word_t rdata;
        int    a1;
        int    a2;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        n_push     = 0;
        n_pop      = 0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;
    endtask

    // One clock cycle: drive requests after the falling edge, check every
    // output against the model, then advance the model past the next rising edge.
    task automatic do_cycle(input logic push, input word_t wd, input logic pop);
        int   sz;
        logic pok;
        logic qok;
        @(negedge CLK);
        fifo.PUSH  = push;
        fifo.WDATA = wd;
        fifo.POP   = pop;
        #1;
        sz  = q.size();
        pok = push && (sz < DEPTH);
        qok = pop && (sz > 0);

        chk("COUNT",  64'(fifo.COUNT),  64'(sz));
        chk("FULL",   64'(fifo.FULL),   64'(sz == DEPTH));
        chk("EMPTY",  64'(fifo.EMPTY),  64'(sz == 0));
        chk("AFULL",  64'(fifo.AFULL),  64'(sz >= 28));
        chk("RVALID", 64'(fifo.RVALID), 64'(exp_rvalid));
        chk("RDATA",  64'(fifo.RDATA),  exp_rvalid ? 64'(exp_rdata) : 64'(0));
        chk("OVF",    64'(fifo.OVF),    64'(exp_ovf));
        chk("UDF",    64'(fifo.UDF),    64'(exp_udf));
        chk("A1",     64'(A1),          64'(n_push % DEPTH));
        chk("CSB1",   64'(CSB1),        64'(!pok));
        chk("WEB1",   64'(WEB1),        64'(!pok));
        chk("I1",     64'(I1),          64'(wd));
        chk("OEB1",   64'(OEB1),        64'(1));
        chk("A2",     64'(A2),          64'(n_pop % DEPTH));
        chk("CSB2",   64'(CSB2),        64'(!qok));
        chk("WEB2",   64'(WEB2),        64'(1));
        chk("OEB2",   64'(OEB2),        64'(!exp_rvalid));

        $display("cyc %0d push=%0b pop=%0b wdata=%h count=%0d rvalid=%0b rdata=%h ovf=%0b udf=%0b",
                 cyc, push, pop, wd, fifo.COUNT, fifo.RVALID, fifo.RDATA, fifo.OVF, fifo.UDF);

        exp_rvalid = qok;
        if (qok) begin
            exp_rdata = q.pop_front();
        end
        if (pok) begin
            q.push_back(wd);
        end
        exp_ovf = push && !pok;
        exp_udf = pop && !qok;
        n_push += int'(pok);
        n_pop  += int'(qok);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1 && q.size() > 0; k++) begin
            do_cycle(1'b0, '0, 1'b1);
        end
        do_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " COUNT"},  64'(fifo.COUNT),  64'(0));
        chk({tag, " EMPTY"},  64'(fifo.EMPTY),  64'(1));
        chk({tag, " FULL"},   64'(fifo.FULL),   64'(0));
        chk({tag, " AFULL"},  64'(fifo.AFULL),  64'(0));
        chk({tag, " RVALID"}, 64'(fifo.RVALID), 64'(0));
        chk({tag, " RDATA"},  64'(fifo.RDATA),  64'(0));
        chk({tag, " OVF"},    64'(fifo.OVF),    64'(0));
        chk({tag, " UDF"},    64'(fifo.UDF),    64'(0));
        chk({tag, " CSB1"},   64'(CSB1),        64'(1));
        chk({tag, " WEB1"},   64'(WEB1),        64'(1));
        chk({tag, " CSB2"},   64'(CSB2),        64'(1));
        chk({tag, " OEB2"},   64'(OEB2),        64'(1));
        chk({tag, " A1"},     64'(A1),          64'(0));
        chk({tag, " A2"},     64'(A2),          64'(0));
    endtask

    initial begin
        // Two pushes then two pops straight after reset; values observed
        // before the rising edge of each row's cycle.
        tbl[0] = '{1'b1, 32'h7B, 1'b0, 0, 1'b0, 32'h0,  0, 0};
        tbl[1] = '{1'b1, 32'h67, 1'b0, 1, 1'b0, 32'h0,  1, 0};
        tbl[2] = '{1'b0, 32'h0,  1'b1, 2, 1'b0, 32'h0,  2, 0};
        tbl[3] = '{1'b0, 32'h0,  1'b1, 1, 1'b1, 32'h7B, 2, 1};
        tbl[4] = '{1'b0, 32'h0,  1'b0, 0, 1'b1, 32'h67, 2, 2};
        tbl[5] = '{1'b0, 32'h0,  1'b0, 0, 1'b0, 32'h0,  2, 2};

        cyc        = 0;
        RST        = 1'b1;
        fifo.PUSH  = 1'b0;
        fifo.POP   = 1'b0;
        fifo.WDATA = '0;
        model_reset();

        // Reset, then idle.
        repeat (2) @(negedge CLK);
        #1;
        check_reset_values("reset");
        RST = 1'b0;
        repeat (3) do_cycle(1'b0, '0, 1'b0);

        // Table-driven push/pop sequence.
        for (int i = 0; i < 6; i++) begin
            do_cycle(tbl[i].push, tbl[i].wdata, tbl[i].pop);
            chk("T_COUNT",  64'(fifo.COUNT),  64'(tbl[i].count));
            chk("T_RVALID", 64'(fifo.RVALID), 64'(tbl[i].rvalid));
            chk("T_RDATA",  64'(fifo.RDATA),  64'(tbl[i].rdata));
            chk("T_A1",     64'(A1),          64'(tbl[i].a1));
            chk("T_A2",     64'(A2),          64'(tbl[i].a2));
        end

        // Fill to full, then overflow attempt.
        for (int i = 0; i < DEPTH; i++) begin
            do_cycle(1'b1, word_t'(32'h100 + i), 1'b0);
        end
        do_cycle(1'b1, 32'hDEAD, 1'b0);
        chk("OVF_PUSH CSB1", 64'(CSB1), 64'(1));
        do_cycle(1'b0, '0, 1'b0);
        chk("FULL_HOLD COUNT", 64'(fifo.COUNT), 64'(32));
        chk("OVF_PULSE", 64'(fifo.OVF), 64'(1));
        do_cycle(1'b0, '0, 1'b0);
        chk("OVF_ONCE", 64'(fifo.OVF), 64'(0));

        // Push+pop together while full: pop wins, push rejected.
        do_cycle(1'b1, 32'hBEEF, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        chk("FULL_PP COUNT",  64'(fifo.COUNT),  64'(31));
        chk("FULL_PP RVALID", 64'(fifo.RVALID), 64'(1));
        chk("FULL_PP RDATA",  64'(fifo.RDATA),  64'(32'h100));
        chk("FULL_PP OVF",    64'(fifo.OVF),    64'(1));
        drain();

        // Pop while empty, then push+pop together while empty.
        do_cycle(1'b0, '0, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        chk("UDF_PULSE", 64'(fifo.UDF), 64'(1));
        do_cycle(1'b1, 32'h55, 1'b1);
        do_cycle(1'b0, '0, 1'b0);
        chk("EMPTY_PP COUNT", 64'(fifo.COUNT), 64'(1));
        chk("EMPTY_PP UDF",   64'(fifo.UDF),   64'(1));
        drain();

        // Fill to 16, then stream push+pop for 40 cycles across the wrap.
        for (int k = 0; k < DEPTH && q.size() < 16; k++) begin
            do_cycle(1'b1, word_t'(32'h300 + k), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            do_cycle(1'b1, word_t'(32'h200 + i), 1'b1);
            chk("STREAM COUNT", 64'(fifo.COUNT), 64'(16));
        end

        // Reset in the middle of the burst, with a read in flight.
        @(negedge CLK);
        #1;
        chk("PRE_RST RVALID", 64'(fifo.RVALID), 64'(exp_rvalid));
        #1;
        RST = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge CLK);
        fifo.PUSH = 1'b0;
        fifo.POP  = 1'b0;
        RST       = 1'b0;
        model_reset();
        do_cycle(1'b0, '0, 1'b0);

        // Randomized traffic with drifting push/pop bias.
        for (int seg = 0; seg < 4; seg++) begin
            int pp;
            int pq;
            case (seg)
                0:       begin pp = 80; pq = 20; end
                1:       begin pp = 20; pq = 80; end
                2:       begin pp = 50; pq = 50; end
                default: begin pp = 90; pq = 15; end
            endcase
            for (int i = 0; i < 100; i++) begin
                do_cycle($urandom_range(0, 99) < pp, word_t'($urandom), $urandom_range(0, 99) < pq);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
